// File: rtl/reg_file_sb_pkg.sv
// regfile_pkg: shared defaults and types for the register file with busy scoreboard.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;
  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: issue/writeback bus for the register file; master drives, slave is the register file.
interface reg_file_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);
  logic                       wrEn;
  logic [AW-1:0]              wrAddr;
  logic [XLEN-1:0]            wrData;
  logic [NRD-1:0][AW-1:0]     rdAddr;
  logic [NRD-1:0][XLEN-1:0]   rdData;
  logic [NRD-1:0]             rdBusy;
  logic                       sbSet;
  logic [AW-1:0]              sbSetAddr;
  logic                       flush;
  logic [AW:0]                busyCnt;
  modport master (
    output wrEn, wrAddr, wrData, rdAddr, sbSet, sbSetAddr, flush,
    input  rdData, rdBusy, busyCnt
  );
  modport slave (
    input  wrEn, wrAddr, wrData, rdAddr, sbSet, sbSetAddr, flush,
    output rdData, rdBusy, busyCnt
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// rf_scoreboard: per-register busy bits with flush > set > release priority and a registered busy count.
// REGFILE_BYPASS_EN: a same-cycle release shows as not-busy on the read ports.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG),
  localparam int CW  = AW + 1
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic                   i_set,
  input  logic [AW-1:0]          i_set_addr,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic                   i_flush,
  input  logic [NRD-1:0][AW-1:0] i_rd_addr,
  output logic [NRD-1:0]         o_rd_busy,
  output logic [AW:0]            o_busy_cnt
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic [AW:0]     r_cnt;
  logic [AW:0]     w_cnt_nxt;
  // Count the next-state vector so busyCnt matches busy[] right after each edge.
  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = '0;
    for (int r = 1; r < NREG; r++) begin
      w_busy_nxt[r] = i_flush ? 1'b0 :
                      (i_set && i_set_addr == AW'(r)) ? 1'b1 :
                      (i_wr_en && i_wr_addr == AW'(r)) ? 1'b0 : r_busy[r];
      w_cnt_nxt += CW'(w_busy_nxt[r]);
    end
    w_busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end
  always_comb begin
    o_rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_BYPASS_EN
      o_rd_busy[i] = (i_wr_en && i_wr_addr == i_rd_addr[i] && i_wr_addr != AW'(ZERO_REG)) ?
                     (!i_flush && i_set && i_set_addr == i_rd_addr[i]) : r_busy[i_rd_addr[i]];
`else
      o_rd_busy[i] = r_busy[i_rd_addr[i]];
`endif
    end
  end
  assign o_busy_cnt = r_cnt;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: NRD-read / 1-write integer register file (x0 = 0) with integrated busy scoreboard.
// REGFILE_BYPASS_EN: write-first forwarding of wrData onto matching read ports.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input logic          Clock,
  input logic          nReset,
  reg_file_sb_if.slave bus
);
  logic [XLEN-1:0] r_regs [1:NREG-1];
  logic            w_wr;
  assign w_wr = bus.wrEn && bus.wrAddr != AW'(ZERO_REG);
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int r = 1; r < NREG; r++) r_regs[r] <= '0;
    end else if (w_wr) begin
      r_regs[bus.wrAddr] <= bus.wrData;
    end
  end
  always_comb begin
    bus.rdData = '0;
    for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_BYPASS_EN
      bus.rdData[i] = (bus.rdAddr[i] == AW'(ZERO_REG)) ? '0 :
                      (w_wr && bus.wrAddr == bus.rdAddr[i]) ? bus.wrData : r_regs[bus.rdAddr[i]];
`else
      bus.rdData[i] = (bus.rdAddr[i] == AW'(ZERO_REG)) ? '0 : r_regs[bus.rdAddr[i]];
`endif
    end
  end
  rf_scoreboard #(.NREG(NREG), .NRD(NRD)) u_sb (
    .Clock      (Clock),
    .nReset     (nReset),
    .i_set      (bus.sbSet),
    .i_set_addr (bus.sbSetAddr),
    .i_wr_en    (bus.wrEn),
    .i_wr_addr  (bus.wrAddr),
    .i_flush    (bus.flush),
    .i_rd_addr  (bus.rdAddr),
    .o_rd_busy  (bus.rdBusy),
    .o_busy_cnt (bus.busyCnt)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard-queue bench for reg_file_sb; honours REGFILE_BYPASS_EN.
module tb_reg_file_sb;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;
  reg_file_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus();
  reg_file_sb #(.XLEN(32), .NREG(32), .NRD(2)) dut (.Clock(clk), .nReset(nrst), .bus(bus));
  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  task automatic idle();
    bus.wrEn = 1'b0; bus.wrAddr = '0; bus.wrData = '0; bus.rdAddr = '0;
    bus.sbSet = 1'b0; bus.sbSetAddr = '0; bus.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    #1 nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    tick();
    exp_q.push_back(32'h0);
    nvec++; e = exp_q.pop_front();
    if (32'(bus.busyCnt) !== e) begin nerr++; $display("FAIL reset_cnt got %0d want %0d", bus.busyCnt, e); end
    for (int a = 0; a < 32; a++) begin
      bus.rdAddr[0] = 5'(a); bus.rdAddr[1] = 5'(a);
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h0);
      #1;
      nvec++; e = exp_q.pop_front();
      if (bus.rdData[0] !== e) begin nerr++; $display("FAIL reset_d0 a=%0d got %h want %h", a, bus.rdData[0], e); end
      nvec++; e = exp_q.pop_front();
      if (bus.rdData[1] !== e) begin nerr++; $display("FAIL reset_d1 a=%0d got %h want %h", a, bus.rdData[1], e); end
      nvec++; e = exp_q.pop_front();
      if (32'(bus.rdBusy[0]) !== e) begin nerr++; $display("FAIL reset_b0 a=%0d got %b want %0d", a, bus.rdBusy[0], e); end
      nvec++; e = exp_q.pop_front();
      if (32'(bus.rdBusy[1]) !== e) begin nerr++; $display("FAIL reset_b1 a=%0d got %b want %0d", a, bus.rdBusy[1], e); end
    end
  endtask

  task automatic test_write();
    idle();
    bus.wrEn = 1'b1; bus.wrAddr = 5'd0; bus.wrData = 32'hFFFF_FFFF;
    exp_q.push_back(32'h0);
    tick(); idle();
    #1;
    nvec++; e = exp_q.pop_front();
    if (bus.rdData[0] !== e) begin nerr++; $display("FAIL x0_write got %h want %h", bus.rdData[0], e); end
    bus.wrEn = 1'b1; bus.wrAddr = 5'd7; bus.wrData = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h1234_5678);
    tick(); idle();
    bus.rdAddr[0] = 5'd7; bus.rdAddr[1] = 5'd7;
    #1;
    nvec++; e = exp_q.pop_front();
    if (bus.rdData[0] !== e) begin nerr++; $display("FAIL x7_p0 got %h want %h", bus.rdData[0], e); end
    nvec++; e = exp_q.pop_front();
    if (bus.rdData[1] !== e) begin nerr++; $display("FAIL x7_p1 got %h want %h", bus.rdData[1], e); end
  endtask

  task automatic test_set_release();
    idle();
    bus.sbSet = 1'b1; bus.sbSetAddr = 5'd3;
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    tick(); idle();
    bus.rdAddr[0] = 5'd3;
    #1;
    nvec++; e = exp_q.pop_front();
    if (32'(bus.rdBusy[0]) !== e) begin nerr++; $display("FAIL set3_busy got %b want %0d", bus.rdBusy[0], e); end
    nvec++; e = exp_q.pop_front();
    if (32'(bus.busyCnt) !== e) begin nerr++; $display("FAIL set3_cnt got %0d want %0d", bus.busyCnt, e); end
    bus.wrEn = 1'b1; bus.wrAddr = 5'd3; bus.wrData = 32'hA5;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'hA5);
    tick(); idle();
    bus.rdAddr[0] = 5'd3;
    #1;
    nvec++; e = exp_q.pop_front();
    if (32'(bus.rdBusy[0]) !== e) begin nerr++; $display("FAIL rel3_busy got %b want %0d", bus.rdBusy[0], e); end
    nvec++; e = exp_q.pop_front();
    if (32'(bus.busyCnt) !== e) begin nerr++; $display("FAIL rel3_cnt got %0d want %0d", bus.busyCnt, e); end
    nvec++; e = exp_q.pop_front();
    if (bus.rdData[0] !== e) begin nerr++; $display("FAIL rel3_data got %h want %h", bus.rdData[0], e); end
  endtask

  task automatic test_set_wins();
    idle();
    bus.sbSet = 1'b1; bus.sbSetAddr = 5'd9;
    tick(); idle();
    bus.sbSet = 1'b1; bus.sbSetAddr = 5'd9;
    bus.wrEn = 1'b1; bus.wrAddr = 5'd9; bus.wrData = 32'h9999;
    exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'h9999);
    tick(); idle();
    bus.rdAddr[1] = 5'd9;
    #1;
    nvec++; e = exp_q.pop_front();
    if (32'(bus.rdBusy[1]) !== e) begin nerr++; $display("FAIL setwin_busy got %b want %0d", bus.rdBusy[1], e); end
    nvec++; e = exp_q.pop_front();
    if (32'(bus.busyCnt) !== e) begin nerr++; $display("FAIL setwin_cnt got %0d want %0d", bus.busyCnt, e); end
    nvec++; e = exp_q.pop_front();
    if (bus.rdData[1] !== e) begin nerr++; $display("FAIL setwin_data got %h want %h", bus.rdData[1], e); end
    bus.wrEn = 1'b1; bus.wrAddr = 5'd9; bus.wrData = 32'h9999;
    tick(); idle();
  endtask

  task automatic test_flush();
    idle();
    for (int k = 0; k < 3; k++) begin
      bus.sbSet = 1'b1; bus.sbSetAddr = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd4;
      tick(); idle();
    end
    exp_q.push_back(32'd3);
    #1;
    nvec++; e = exp_q.pop_front();
    if (32'(bus.busyCnt) !== e) begin nerr++; $display("FAIL preflush_cnt got %0d want %0d", bus.busyCnt, e); end
    bus.flush = 1'b1; bus.sbSet = 1'b1; bus.sbSetAddr = 5'd0;
    bus.wrEn = 1'b1; bus.wrAddr = 5'd1; bus.wrData = 32'h11;
    exp_q.push_back(32'd0);
    tick(); idle();
    #1;
    nvec++; e = exp_q.pop_front();
    if (32'(bus.busyCnt) !== e) begin nerr++; $display("FAIL flush_cnt got %0d want %0d", bus.busyCnt, e); end
    for (int a = 0; a < 5; a++) begin
      bus.rdAddr[0] = 5'(a);
      exp_q.push_back(32'd0);
      #1;
      nvec++; e = exp_q.pop_front();
      if (32'(bus.rdBusy[0]) !== e) begin nerr++; $display("FAIL flush_busy a=%0d got %b want %0d", a, bus.rdBusy[0], e); end
    end
    bus.rdAddr[0] = 5'd1;
    exp_q.push_back(32'h11);
    #1;
    nvec++; e = exp_q.pop_front();
    if (bus.rdData[0] !== e) begin nerr++; $display("FAIL flush_write got %h want %h", bus.rdData[0], e); end
    bus.sbSet = 1'b1; bus.sbSetAddr = 5'd0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick(); idle();
    #1;
    nvec++; e = exp_q.pop_front();
    if (32'(bus.rdBusy[0]) !== e) begin nerr++; $display("FAIL x0_busy got %b want %0d", bus.rdBusy[0], e); end
    nvec++; e = exp_q.pop_front();
    if (32'(bus.busyCnt) !== e) begin nerr++; $display("FAIL x0_cnt got %0d want %0d", bus.busyCnt, e); end
  endtask

  task automatic test_bypass();
    idle();
    bus.wrEn = 1'b1; bus.wrAddr = 5'd10; bus.wrData = 32'h33;
    tick(); idle();
    bus.sbSet = 1'b1; bus.sbSetAddr = 5'd10;
    tick(); idle();
    bus.wrEn = 1'b1; bus.wrAddr = 5'd10; bus.wrData = 32'h55; bus.rdAddr[1] = 5'd10;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h55); exp_q.push_back(32'd0);
`else
    exp_q.push_back(32'h33); exp_q.push_back(32'd1);
`endif
    #1;
    nvec++; e = exp_q.pop_front();
    if (bus.rdData[1] !== e) begin nerr++; $display("FAIL byp_data got %h want %h", bus.rdData[1], e); end
    nvec++; e = exp_q.pop_front();
    if (32'(bus.rdBusy[1]) !== e) begin nerr++; $display("FAIL byp_busy got %b want %0d", bus.rdBusy[1], e); end
    exp_q.push_back(32'h55); exp_q.push_back(32'd0);
    tick(); idle();
    bus.rdAddr[1] = 5'd10;
    #1;
    nvec++; e = exp_q.pop_front();
    if (bus.rdData[1] !== e) begin nerr++; $display("FAIL post_data got %h want %h", bus.rdData[1], e); end
    nvec++; e = exp_q.pop_front();
    if (32'(bus.rdBusy[1]) !== e) begin nerr++; $display("FAIL post_busy got %b want %0d", bus.rdBusy[1], e); end
  endtask

  task automatic test_async_reset();
    idle();
    bus.wrEn = 1'b1; bus.wrAddr = 5'd5; bus.wrData = 32'hDEAD_BEEF;
    bus.sbSet = 1'b1; bus.sbSetAddr = 5'd6;
    exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'd1);
    tick(); idle();
    bus.rdAddr[0] = 5'd5; bus.rdAddr[1] = 5'd6;
    #1;
    nvec++; e = exp_q.pop_front();
    if (bus.rdData[0] !== e) begin nerr++; $display("FAIL pre_rst_data got %h want %h", bus.rdData[0], e); end
    nvec++; e = exp_q.pop_front();
    if (32'(bus.rdBusy[1]) !== e) begin nerr++; $display("FAIL pre_rst_busy got %b want %0d", bus.rdBusy[1], e); end
    nrst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    nvec++; e = exp_q.pop_front();
    if (bus.rdData[0] !== e) begin nerr++; $display("FAIL rst_data got %h want %h", bus.rdData[0], e); end
    nvec++; e = exp_q.pop_front();
    if (32'(bus.rdBusy[1]) !== e) begin nerr++; $display("FAIL rst_busy got %b want %0d", bus.rdBusy[1], e); end
    nvec++; e = exp_q.pop_front();
    if (32'(bus.busyCnt) !== e) begin nerr++; $display("FAIL rst_cnt got %0d want %0d", bus.busyCnt, e); end
    #1 nrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_set_release();
    test_set_wins();
    test_flush();
    test_bypass();
    test_async_reset();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
